// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: DE/HV-mode TFT timing generator with frame-buffer stream
// input, built-in colour bars, sticky underflow flag and run-time enable.
module lcd_timing_gen #(
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FRONT  = 210,
   parameter int unsigned H_SYNC   = 1,
   parameter int unsigned H_BACK   = 45,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FRONT  = 22,
   parameter int unsigned V_SYNC   = 1,
   parameter int unsigned V_BACK   = 22,
   parameter int unsigned CW       = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            enable,
   input  logic            mode,
   input  logic [3*CW-1:0] pix_data,
   input  logic            pix_valid,
   output logic            pix_ready,
   input  logic            underflow_clr,
   output logic            underflow,
   output logic            sof,
   output logic [3*CW-1:0] RGB,
   output logic            DEN,
   output logic            HSD,
   output logic            VSD,
   output logic            STBYB
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned BAR_W   = H_ACTIVE / 8;

   // Region bounds carry one extra bit so an end bound equal to the total
   // (zero front porch) cannot wrap.
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [HW:0]   H_SYN_END = (HW+1)'(H_SYNC);
   localparam logic [HW:0]   H_ACT_BEG = (HW+1)'(H_SYNC + H_BACK);
   localparam logic [HW:0]   H_ACT_END = (HW+1)'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [VW:0]   V_SYN_END = (VW+1)'(V_SYNC);
   localparam logic [VW:0]   V_ACT_BEG = (VW+1)'(V_SYNC + V_BACK);
   localparam logic [VW:0]   V_ACT_END = (VW+1)'(V_SYNC + V_BACK + V_ACTIVE);

   logic [HW-1:0]   h_cnt;
   logic [VW-1:0]   v_cnt;
   logic [HW-1:0]   h_nxt_c;
   logic [VW-1:0]   v_nxt_c;
   logic            mode_q;
   logic            hs_c;
   logic            vs_c;
   logic            act_c;
   logic            origin_c;
   logic            miss_c;
   logic [HW-1:0]   x_c;
   logic [2:0]      bar_c;
   logic [3*CW-1:0] rgb_nxt_c;

   // Region decode and next counter state from the registered counters.
   always_comb begin
      hs_c     = ({1'b0, h_cnt} < H_SYN_END);
      vs_c     = ({1'b0, v_cnt} < V_SYN_END);
      act_c    = ({1'b0, h_cnt} >= H_ACT_BEG) && ({1'b0, h_cnt} < H_ACT_END) &&
                 ({1'b0, v_cnt} >= V_ACT_BEG) && ({1'b0, v_cnt} < V_ACT_END);
      origin_c = (h_cnt == '0) && (v_cnt == '0);
      h_nxt_c  = h_cnt + HW'(1);
      v_nxt_c  = v_cnt;
      if (h_cnt == H_LAST) begin
         h_nxt_c = '0;
         v_nxt_c = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end
   end

   // Stream handshake, underflow detect and next pixel value.
   always_comb begin
      pix_ready = enable && act_c && !mode_q;
      miss_c    = pix_ready && !pix_valid;
      x_c       = h_cnt - HW'(H_SYNC + H_BACK);
      bar_c     = 3'(x_c / HW'(BAR_W));
      rgb_nxt_c = '0;
      if (act_c) begin
         if (mode_q) begin
            rgb_nxt_c = {{CW{bar_c[2]}}, {CW{bar_c[1]}}, {CW{bar_c[0]}}};
         end else if (pix_valid) begin
            rgb_nxt_c = pix_data;
         end
      end
   end

   // Horizontal/vertical counters; held at the origin while disabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!enable) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_nxt_c;
         v_cnt <= v_nxt_c;
      end
   end

   // Mode is latched only at frame start so a frame never mixes sources.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q <= 1'b0;
      end else if (enable && origin_c) begin
         mode_q <= mode;
      end
   end

   // Panel outputs, one clock behind the counter state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         HSD   <= 1'b1;
         VSD   <= 1'b1;
         DEN   <= 1'b0;
         RGB   <= '0;
         sof   <= 1'b0;
         STBYB <= 1'b0;
      end else if (!enable) begin
         HSD   <= 1'b1;
         VSD   <= 1'b1;
         DEN   <= 1'b0;
         RGB   <= '0;
         sof   <= 1'b0;
         STBYB <= 1'b0;
      end else begin
         HSD   <= !hs_c;
         VSD   <= !vs_c;
         DEN   <= act_c;
         RGB   <= rgb_nxt_c;
         sof   <= origin_c;
         STBYB <= 1'b1;
      end
   end

   // Sticky underflow; a new miss wins over a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         underflow <= 1'b0;
      end else if (miss_c) begin
         underflow <= 1'b1;
      end else if (underflow_clr) begin
         underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Testbench for lcd_timing_gen: directed phases with randomized pixel
// traffic, checked against a frame-position reference model.
module tb_lcd_timing_gen;

   localparam int unsigned HA = 8, HF = 2, HS = 1, HB = 2;
   localparam int unsigned VA = 4, VF = 1, VS = 1, VB = 1, CW = 8;
   localparam int HT = 13;
   localparam int FR = 91;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            enable;
   logic            mode;
   logic [3*CW-1:0] pix_data;
   logic            pix_valid;
   logic            pix_ready;
   logic            underflow_clr;
   logic            underflow;
   logic            sof;
   logic [3*CW-1:0] RGB;
   logic            DEN;
   logic            HSD;
   logic            VSD;
   logic            STBYB;

   lcd_timing_gen #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CW(CW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .underflow_clr(underflow_clr), .underflow(underflow), .sof(sof),
      .RGB(RGB), .DEN(DEN), .HSD(HSD), .VSD(VSD), .STBYB(STBYB)
   );

   always #5 clk = ~clk;

   // Reference model: frame position 0..FR-1 plus latched mode and flag.
   int         pos;
   bit         m_mq;
   bit         m_uf;
   bit         m_took;
   bit         e_hsd, e_vsd, e_den, e_sof, e_stbyb;
   logic [23:0] e_rgb;
   logic [23:0] bars [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                             24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;
   int st_den, st_hsl, st_vsl, st_sof;

   function automatic bit m_act(input int p);
      int h, v;
      h = p % HT;
      v = p / HT;
      return (h >= int'(HS + HB)) && (h < int'(HS + HB + HA)) &&
             (v >= int'(VS + VB)) && (v < int'(VS + VB + VA));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      pos = 0; m_mq = 0; m_uf = 0; m_took = 0;
      e_hsd = 1; e_vsd = 1; e_den = 0; e_sof = 0; e_stbyb = 0; e_rgb = '0;
   endtask

   // One clock: check ready, advance the model at the edge, check outputs.
   task automatic tick();
      int  h, v;
      bit  a;
      #1;
      chk("pix_ready", 32'(pix_ready), 32'(enable && m_act(pos) && !m_mq));
      @(posedge clk);
      if (enable) begin
         h = pos % HT;
         v = pos / HT;
         a = m_act(pos);
         e_hsd   = !(h < int'(HS));
         e_vsd   = !(v < int'(VS));
         e_den   = a;
         e_sof   = (pos == 0);
         e_stbyb = 1;
         m_took  = a && !m_mq && pix_valid;
         if (!a)        e_rgb = '0;
         else if (m_mq) e_rgb = bars[h - int'(HS + HB)];
         else           e_rgb = pix_valid ? pix_data : 24'h0;
         if (a && !m_mq && !pix_valid) m_uf = 1;
         else if (underflow_clr)       m_uf = 0;
         if (pos == 0) m_mq = mode;
         pos = (pos + 1) % FR;
      end else begin
         e_hsd = 1; e_vsd = 1; e_den = 0; e_rgb = '0; e_sof = 0; e_stbyb = 0;
         m_took = 0;
         if (underflow_clr) m_uf = 0;
         pos = 0;
      end
      @(negedge clk);
      chk("HSD", 32'(HSD), 32'(e_hsd));
      chk("VSD", 32'(VSD), 32'(e_vsd));
      chk("DEN", 32'(DEN), 32'(e_den));
      chk("RGB", 32'(RGB), 32'(e_rgb));
      chk("sof", 32'(sof), 32'(e_sof));
      chk("STBYB", 32'(STBYB), 32'(e_stbyb));
      chk("underflow", 32'(underflow), 32'(m_uf));
      st_den += int'(DEN);
      st_hsl += int'(!HSD);
      st_vsl += int'(!VSD);
      st_sof += int'(sof);
   endtask

   task automatic run_to(input int target);
      int g;
      g = 0;
      while (pos != target && g < 200) begin
         tick();
         g++;
      end
      if (pos != target) begin
         n_total++;
         n_fail++;
         $error("FAIL run_to timeout observed_pos=%0d expected_pos=%0d", pos, target);
      end
   endtask

   task automatic run_to_active();
      int g;
      g = 0;
      while (!(m_act(pos) && !m_mq) && g < 200) begin
         tick();
         g++;
      end
      if (!(m_act(pos) && !m_mq)) begin
         n_total++;
         n_fail++;
         $error("FAIL run_to_active timeout observed_pos=%0d expected=active", pos);
      end
   endtask

   task automatic rand_cycles(input int n, input int clr_odds);
      for (int i = 0; i < n; i++) begin
         pix_data      = 24'($urandom);
         pix_valid     = ($urandom_range(3) != 0);
         underflow_clr = ($urandom_range(clr_odds - 1) == 0);
         tick();
      end
      underflow_clr = 0;
   endtask

   initial begin
      reset_n = 0; enable = 0; mode = 0; pix_data = '0; pix_valid = 0; underflow_clr = 0;
      model_reset();
      st_den = 0; st_hsl = 0; st_vsl = 0; st_sof = 0;

      // Reset state
      #12;
      chk("rst_HSD", 32'(HSD), 32'd1);
      chk("rst_VSD", 32'(VSD), 32'd1);
      chk("rst_DEN", 32'(DEN), 32'd0);
      chk("rst_RGB", 32'(RGB), 32'd0);
      chk("rst_sof", 32'(sof), 32'd0);
      chk("rst_STBYB", 32'(STBYB), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_pix_ready", 32'(pix_ready), 32'd0);
      @(negedge clk);
      reset_n = 1;

      // Phase 1: stream mode, always valid, incrementing data
      enable = 1; pix_valid = 1; pix_data = 24'h000001;
      for (int i = 0; i < 2 * FR; i++) begin
         if (i == FR) begin
            st_den = 0; st_hsl = 0; st_vsl = 0; st_sof = 0;
         end
         tick();
         if (m_took) pix_data = pix_data + 24'h1;
      end
      chk("den_per_frame", 32'(st_den), 32'd32);
      chk("hsd_low_per_frame", 32'(st_hsl), 32'd7);
      chk("vsd_low_per_frame", 32'(st_vsl), 32'd13);
      chk("sof_per_frame", 32'(st_sof), 32'd1);

      // Phase 2: colour bars for a whole frame, random valid ignored
      mode = 1;
      run_to(0);
      for (int i = 0; i < FR + 5; i++) begin
         pix_valid = ($urandom_range(1) != 0);
         pix_data  = 24'($urandom);
         tick();
      end
      chk("bars_no_underflow", 32'(underflow), 32'd0);

      // Phase 3: stream with random gaps and clears, then directed cases
      mode = 0;
      run_to(0);
      rand_cycles(2 * FR, 8);
      pix_valid = 1;
      underflow_clr = 1;
      tick();
      underflow_clr = 0;
      run_to_active();
      pix_valid = 0;
      tick();
      pix_valid = 1;
      chk("uf_set", 32'(underflow), 32'd1);
      tick();
      chk("uf_sticky", 32'(underflow), 32'd1);
      underflow_clr = 1;
      tick();
      underflow_clr = 0;
      chk("uf_cleared", 32'(underflow), 32'd0);
      run_to_active();
      pix_valid = 0; underflow_clr = 1;
      tick();
      pix_valid = 1; underflow_clr = 0;
      chk("uf_set_beats_clr", 32'(underflow), 32'd1);

      // Phase 4: mode toggles mid-frame take effect at next frame
      run_to(3 * HT);
      mode = 1;
      run_to(0);
      for (int i = 0; i < FR; i++) tick();
      run_to(3 * HT);
      mode = 0;
      run_to(0);
      for (int i = 0; i < FR; i++) begin
         pix_data = 24'($urandom);
         tick();
      end

      // Phase 5: disable mid-frame, then re-enable
      run_to(3 * HT + 5);
      enable = 0;
      tick();
      chk("dis_STBYB", 32'(STBYB), 32'd0);
      chk("dis_HSD", 32'(HSD), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      enable = 1;
      tick();
      chk("reen_sof", 32'(sof), 32'd1);
      chk("reen_STBYB", 32'(STBYB), 32'd1);
      st_sof = 0;
      for (int i = 0; i < FR; i++) tick();
      chk("reen_sof_count", 32'(st_sof), 32'd1);
      chk("reen_sof_period", 32'(sof), 32'd1);

      // Phase 6: async reset mid-line, then restart
      run_to(2 * HT + 6);
      pix_valid = 0;
      tick();
      pix_valid = 1;
      #2;
      reset_n = 0;
      #1;
      model_reset();
      chk("arst_HSD", 32'(HSD), 32'd1);
      chk("arst_VSD", 32'(VSD), 32'd1);
      chk("arst_DEN", 32'(DEN), 32'd0);
      chk("arst_RGB", 32'(RGB), 32'd0);
      chk("arst_sof", 32'(sof), 32'd0);
      chk("arst_STBYB", 32'(STBYB), 32'd0);
      chk("arst_underflow", 32'(underflow), 32'd0);
      chk("arst_pix_ready", 32'(pix_ready), 32'd0);
      @(negedge clk);
      reset_n = 1;
      tick();
      chk("restart_sof", 32'(sof), 32'd1);
      rand_cycles(FR + 10, 16);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Parametrised DE/HV-mode TFT LCD timing generator. Drives RGB, DEN, HSD, VSD and STBYB from the pixel clock, replacing the static tie-offs on the panel pins. Pulls pixels from a frame-buffer stream using a valid/ready handshake. Also has a built-in colour-bar mode, sticky underflow detection and a run-time enable.

Parameters:
H_ACTIVE, 800, visible pixels per line; must be a multiple of 8
H_FRONT, 210, horizontal front porch (clocks)
H_SYNC, 1, HSD low width (clocks); must be at least 1
H_BACK, 45, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 22, vertical front porch (lines)
V_SYNC, 1, VSD low width (lines); must be at least 1
V_BACK, 22, vertical back porch (lines)
CW, 8, bits per colour component; RGB width is 3*CW

Ports:
clk  in  1  pixel clock (same as LCDCLK)
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = run timing; 0 = blank, counters held
mode  in  1  0 = stream pixels, 1 = colour bars; sampled only at frame start
pix_data  in  3*CW  pixel {R,G,B} from frame buffer
pix_valid  in  1  pix_data valid
pix_ready  out  1  generator consumes pix_data this cycle
underflow_clr  in  1  clears underflow flag
underflow  out  1  sticky; a pixel was needed but pix_valid was 0
sof  out  1  one-clock pulse at frame start (h=0, v=0)
RGB  out  3*CW  panel pixel data {R,G,B}
DEN  out  1  data enable
HSD  out  1  horizontal sync, active low
VSD  out  1  vertical sync, active low
STBYB  out  1  panel standby, active low

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 and wraps to 0.
- Counter widths: $clog2 of the respective total.
- Regions, evaluated from the counter values:
  - hs = h_cnt < H_SYNC
  - vs = v_cnt < V_SYNC
  - act = (H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE) && (V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_ACTIVE)
- Output latency: all panel outputs are registered, one clock after the counter state. So HSD = ~hs, VSD = ~vs and DEN = act, each delayed by one clock.
- pix_ready = enable && act && mode_q==0. This is combinational from the registered counters and mode_q.
- Stream mode, ready && valid: pix_data is registered onto RGB next clock.
- Stream mode, ready && !valid: RGB is 0 next clock, underflow is set, and no pixel is consumed.
- When DEN is 0, RGB is 0.
- Colour-bar mode: the active pixel index x runs 0..H_ACTIVE-1. The bar index is b = x / (H_ACTIVE/8). RGB = {{CW{b[2]}},{CW{b[1]}},{CW{b[0]}}}.
- pix_ready stays 0 in colour-bar mode, and underflow is never set in that mode.
- mode_q: loads mode when the counter state is (0,0) and enable is 1. A mode change mid-frame takes effect on the next frame.
- sof: registered with the same latency as the panel outputs. It pulses with the first HSD-low clock of VSD-low line 0.
- underflow:
  - set has priority over underflow_clr in the same cycle
  - cleared only by underflow_clr or reset
- enable = 0:
  - next clock, counters go to (0,0) and are held there
  - HSD = 1, VSD = 1, DEN = 0, RGB = 0, sof = 0, STBYB = 0, pix_ready = 0
  - a deassert mid-frame truncates the frame immediately
- enable 0 -> 1: STBYB goes 1 the next clock. Timing starts from (0,0): first sof is the clock after enable is seen high, and mode_q loads at that point.
- Reset (async assert, no sync-deassert requirement inside the block): h_cnt = 0, v_cnt = 0, mode_q = 0, HSD = 1, VSD = 1, DEN = 0, RGB = 0, sof = 0, underflow = 0, STBYB = 0.
- Reset mid-frame aborts the frame. There is no recovery beyond a restart from (0,0).

Test Plan:
Bench uses H_ACTIVE=8, H_FRONT=2, H_SYNC=1, H_BACK=2, V_ACTIVE=4, V_FRONT=1, V_SYNC=1, V_BACK=1, CW=8, giving H_TOTAL=13, V_TOTAL=7 and 91 clocks per frame.
1. Reset, then enable=1, mode=0, pix_valid=1 with incrementing data -> sof every 91 clocks; HSD low 1 of 13 clocks; VSD low 13 of 91 clocks; DEN high 32 clocks per frame, in 4 runs of 8 starting at h_cnt=3, v_cnt=2; RGB equals the accepted data one clock after each ready&&valid.
2. mode=1 for a whole frame -> each active line reads 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF (1 pixel each); pix_ready never 1; underflow stays 0.
3. Stream mode, drop pix_valid for one active cycle -> RGB=0 on that pixel; underflow=1 and stays 1; next pixel accepted normally; pulse underflow_clr -> underflow=0. underflow_clr coinciding with a new miss -> underflow stays 1.
4. Toggle mode at mid-frame (v_cnt=3) -> pattern unchanged until the next sof, then switches.
5. enable=0 at h_cnt=5, v_cnt=3 -> next clock HSD=1, VSD=1, DEN=0, STBYB=0, pix_ready=0; re-enable -> STBYB=1 and sof one clock later; full 91-clock frame follows.
6. Assert reset_n=0 mid-line with no clock edge -> outputs take their reset values immediately (async); release -> the enabled generator restarts from (0,0).
